axi_stream_to_galapagos_bridge: RTL and testbench

Egress bridge that packs a FINN-style AXI-Stream output (narrow, headerless words) into Galapagos packets. Each packet is `GALAPAGOS_NUM_TRANSFERS` beats of `GALAPAGOS_DATA_WIDTH` bits, carrying TKEEP, TDEST, TID and TLAST. It sits downstream of the FINN kernel and is the mirror stage of `galapagos_to_axi_stream_bridge`, feeding the Galapagos router.

---
 rtl/galapagos_bridge_pkg.sv | 20 ++
 rtl/axi_stream_to_galapagos_bridge.sv | 153 +++++++++++++++
 tb/tb_axi_stream_to_galapagos_bridge.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/galapagos_bridge_pkg.sv
// Shared types and helpers for the AXI-Stream <-> Galapagos bridges.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package galapagos_bridge_pkg;

    // Fill collects narrow words into one beat; send presents that beat to the router.
    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_SEND = 1'b1
    } gp_bridge_state_t;

    localparam int TDEST_W = 8;
    localparam int TID_W   = 8;

    // Number of byte-enable bits needed for a bus of the given width.
    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axi_stream_to_galapagos_bridge.sv
// Packs headerless AXI-Stream words into Galapagos beats/packets with TKEEP, TDEST, TID and TLAST.
// Latency: a beat is presented one cycle after its completing word is accepted.
// Backpressure: no skid buffer; input is stalled for every cycle a beat waits on the router.
module axi_stream_to_galapagos_bridge
    import galapagos_bridge_pkg::*;
#(
    parameter int AXI_STREAM_DATA_WIDTH   = 16,
    parameter int GALAPAGOS_DATA_WIDTH    = 32,
    parameter int GALAPAGOS_NUM_TRANSFERS = 2,
    parameter int GALAPAGOS_TID           = 4
) (
    input  logic                                          i_clk,
    input  logic                                          i_aresetn,
    input  logic [31:0]                                   i_core_TID,
    input  logic [TDEST_W-1:0]                            i_dest_TDEST,
    input  logic                                          i_axis_TVALID,
    output logic                                          o_axis_TREADY,
    input  logic [AXI_STREAM_DATA_WIDTH-1:0]              i_axis_TDATA,
    input  logic                                          i_axis_TLAST,
    output logic                                          o_gp_TVALID,
    input  logic                                          i_gp_TREADY,
    output logic [GALAPAGOS_DATA_WIDTH-1:0]               o_gp_TDATA,
    output logic [keep_width(GALAPAGOS_DATA_WIDTH)-1:0]   o_gp_TKEEP,
    output logic [TDEST_W-1:0]                            o_gp_TDEST,
    output logic [TID_W-1:0]                              o_gp_TID,
    output logic                                          o_gp_TLAST
);

    localparam int ADW        = AXI_STREAM_DATA_WIDTH;
    localparam int GDW        = GALAPAGOS_DATA_WIDTH;
    localparam int N          = GALAPAGOS_NUM_TRANSFERS;
    localparam int W          = GDW / ADW;
    localparam int KEEP_W     = keep_width(GDW);
    localparam int SLOT_KEEP  = keep_width(ADW);
    localparam int WORD_CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int BEAT_CNT_W = (N > 1) ? $clog2(N) : 1;

    // Parameter sanity: a bad configuration must not elaborate silently.
    if (ADW <= 0 || (ADW % 8) != 0) begin : g_chk_adw
        $error("AXI_STREAM_DATA_WIDTH must be a positive multiple of 8");
    end
    if (GDW < ADW || (GDW % ADW) != 0) begin : g_chk_gdw
        $error("GALAPAGOS_DATA_WIDTH must be an integer multiple of AXI_STREAM_DATA_WIDTH");
    end
    if (N < 1) begin : g_chk_n
        $error("GALAPAGOS_NUM_TRANSFERS must be at least 1");
    end
    if (GALAPAGOS_TID < 0 || GALAPAGOS_TID >= (1 << TID_W)) begin : g_chk_tid
        $error("GALAPAGOS_TID does not fit in the TID field");
    end

    gp_bridge_state_t        state_q;
    gp_bridge_state_t        state_d;
    logic [WORD_CNT_W-1:0]   word_cnt;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [GDW-1:0]          data_q;
    logic [KEEP_W-1:0]       keep_q;
    logic [TDEST_W-1:0]      tdest_q;
    logic                    tlast_q;

    logic                    word_acc;
    logic                    beat_acc;
    logic                    slot_full;
    logic                    beat_done;
    logic                    last_beat;

    // Upper TID bits are reserved by integration and intentionally ignored.
    logic unused_tid_hi;
    assign unused_tid_hi = &{1'b0, i_core_TID[31:TID_W]};

    assign word_acc  = i_axis_TVALID && o_axis_TREADY;
    assign beat_acc  = o_gp_TVALID && i_gp_TREADY;
    assign slot_full = (word_cnt == WORD_CNT_W'(W - 1));
    assign beat_done = word_acc && (slot_full || i_axis_TLAST);
    assign last_beat = (beat_cnt == BEAT_CNT_W'(N - 1));

    // State register; reset discards whatever partial beat was being built.
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; ready is held low while reset is asserted.
    always_comb begin
        state_d       = state_q;
        o_axis_TREADY = 1'b0;
        o_gp_TVALID   = 1'b0;
        case (state_q)
            S_FILL: begin
                o_axis_TREADY = i_aresetn;
                if (beat_done) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                o_gp_TVALID = 1'b1;
                if (i_gp_TREADY) begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // Slot and beat counters; beat_cnt wraps to zero after any beat flagged TLAST.
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            word_cnt <= '0;
            beat_cnt <= '0;
        end else if (beat_acc) begin
            word_cnt <= '0;
            beat_cnt <= tlast_q ? '0 : beat_cnt + 1'b1;
        end else if (word_acc && !beat_done) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    // Beat assembly: slot 0 is least significant; unfilled slots stay zero with keep zero.
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            data_q  <= '0;
            keep_q  <= '0;
            tdest_q <= '0;
            tlast_q <= 1'b0;
        end else if (beat_acc) begin
            data_q  <= '0;
            keep_q  <= '0;
            tlast_q <= 1'b0;
        end else if (word_acc) begin
            data_q[int'(word_cnt)*ADW +: ADW]             <= i_axis_TDATA;
            keep_q[int'(word_cnt)*SLOT_KEEP +: SLOT_KEEP] <= '1;
            // Destination is fixed for the whole packet by its first word.
            if (word_cnt == '0 && beat_cnt == '0) begin
                tdest_q <= i_dest_TDEST;
            end
            if (beat_done) begin
                tlast_q <= last_beat || i_axis_TLAST;
            end
        end
    end

    assign o_gp_TDATA = data_q;
    assign o_gp_TKEEP = keep_q;
    assign o_gp_TDEST = tdest_q;
    assign o_gp_TLAST = tlast_q;
    assign o_gp_TID   = i_core_TID[TID_W-1:0];

endmodule

// File: tb/tb_axi_stream_to_galapagos_bridge.sv
// Bench for the egress bridge: default configuration (W=2, N=2) and a W=1, N=3 instance.
// Latency: n/a (testbench).
// Backpressure: router ready is driven by the bench.
module tb_axi_stream_to_galapagos_bridge;

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  keep;
        logic [7:0]  dest;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [2:0]  nw;
        logic [63:0] words;
        logic        early;
        logic [7:0]  dest;
        logic [1:0]  nb;
        logic [63:0] exp_dat;
        logic [7:0]  exp_keep;
        logic [1:0]  exp_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] core_tid;

    logic [7:0]  a_dest;
    logic        a_axis_tvalid, a_axis_tready, a_axis_tlast;
    logic [15:0] a_axis_tdata;
    logic        a_gp_tvalid, a_gp_tready, a_gp_tlast;
    logic [31:0] a_gp_tdata;
    logic [3:0]  a_gp_tkeep;
    logic [7:0]  a_gp_tdest, a_gp_tid;

    logic [7:0]  b_dest;
    logic        b_axis_tvalid, b_axis_tready, b_axis_tlast;
    logic [15:0] b_axis_tdata;
    logic        b_gp_tvalid, b_gp_tready, b_gp_tlast;
    logic [15:0] b_gp_tdata;
    logic [1:0]  b_gp_tkeep;
    logic [7:0]  b_gp_tdest, b_gp_tid;

    beat_t qa[$];
    beat_t qb[$];
    vec_t  vecs[5];
    int    checks;
    int    failures;

    always #5 clk = ~clk;

    axi_stream_to_galapagos_bridge dut_a (
        .i_clk(clk), .i_aresetn(aresetn), .i_core_TID(core_tid), .i_dest_TDEST(a_dest),
        .i_axis_TVALID(a_axis_tvalid), .o_axis_TREADY(a_axis_tready),
        .i_axis_TDATA(a_axis_tdata), .i_axis_TLAST(a_axis_tlast),
        .o_gp_TVALID(a_gp_tvalid), .i_gp_TREADY(a_gp_tready), .o_gp_TDATA(a_gp_tdata),
        .o_gp_TKEEP(a_gp_tkeep), .o_gp_TDEST(a_gp_tdest), .o_gp_TID(a_gp_tid),
        .o_gp_TLAST(a_gp_tlast)
    );

    axi_stream_to_galapagos_bridge #(
        .AXI_STREAM_DATA_WIDTH(16), .GALAPAGOS_DATA_WIDTH(16), .GALAPAGOS_NUM_TRANSFERS(3)
    ) dut_b (
        .i_clk(clk), .i_aresetn(aresetn), .i_core_TID(core_tid), .i_dest_TDEST(b_dest),
        .i_axis_TVALID(b_axis_tvalid), .o_axis_TREADY(b_axis_tready),
        .i_axis_TDATA(b_axis_tdata), .i_axis_TLAST(b_axis_tlast),
        .o_gp_TVALID(b_gp_tvalid), .i_gp_TREADY(b_gp_tready), .o_gp_TDATA(b_gp_tdata),
        .o_gp_TKEEP(b_gp_tkeep), .o_gp_TDEST(b_gp_tdest), .o_gp_TID(b_gp_tid),
        .o_gp_TLAST(b_gp_tlast)
    );

    task automatic compare_beat(input string name, input beat_t got, input logic [7:0] tid,
                                inout beat_t q[$]);
        beat_t exp;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected beat got dat=%h keep=%h dest=%h last=%b required none",
                     name, got.dat, got.keep, got.dest, got.last);
        end else begin
            exp = q.pop_front();
            if (got !== exp || tid !== 8'h04) begin
                failures++;
                $display("FAIL %s got dat=%h keep=%h dest=%h tid=%h last=%b required dat=%h keep=%h dest=%h tid=04 last=%b",
                         name, got.dat, got.keep, got.dest, tid, got.last,
                         exp.dat, exp.keep, exp.dest, exp.last);
            end
        end
    endtask

    task automatic push_a(input logic [31:0] dat, input logic [3:0] keep,
                          input logic [7:0] dest, input logic last);
        beat_t e;
        e = '{dat: dat, keep: keep, dest: dest, last: last};
        qa.push_back(e);
    endtask

    // Offer one word on the selected instance and wait (bounded) for acceptance.
    task automatic send_word(input bit sel_b, input logic [15:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        if (sel_b) begin
            b_axis_tvalid = 1'b1; b_axis_tdata = d; b_axis_tlast = l;
        end else begin
            a_axis_tvalid = 1'b1; a_axis_tdata = d; a_axis_tlast = l;
        end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if ((sel_b ? b_axis_tready : a_axis_tready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        a_axis_tvalid = 1'b0; a_axis_tlast = 1'b0;
        b_axis_tvalid = 1'b0; b_axis_tlast = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout word=%h got tready=0 required 1", d);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        for (int j = 0; j < int'(v.nb); j++) begin
            push_a(v.exp_dat[j*32 +: 32], v.exp_keep[j*4 +: 4], v.dest, v.exp_last[j]);
        end
        a_dest = v.dest;
        for (int k = 0; k < int'(v.nw); k++) begin
            send_word(1'b0, v.words[k*16 +: 16], v.early && (k == int'(v.nw) - 1));
        end
    endtask

    initial begin
        vec_t  tv;
        beat_t eb;
        checks = 0;
        failures = 0;
        aresetn = 1'b0;
        core_tid = 32'hABCD_EF04;
        a_dest = 8'd4; a_axis_tvalid = 1'b0; a_axis_tdata = '0; a_axis_tlast = 1'b0; a_gp_tready = 1'b1;
        b_dest = 8'd5; b_axis_tvalid = 1'b0; b_axis_tdata = '0; b_axis_tlast = 1'b0; b_gp_tready = 1'b1;

        vecs[0] = '{nw: 3'd4, words: 64'h2222_1111_ABCD_EFAB, early: 1'b0, dest: 8'd4, nb: 2'd2,
                    exp_dat: 64'h2222_1111_ABCD_EFAB, exp_keep: 8'hFF, exp_last: 2'b10};
        vecs[1] = '{nw: 3'd1, words: 64'h0000_0000_0000_1234, early: 1'b1, dest: 8'd4, nb: 2'd1,
                    exp_dat: 64'h0000_0000_0000_1234, exp_keep: 8'h03, exp_last: 2'b01};
        vecs[2] = '{nw: 3'd3, words: 64'h0000_0003_0002_0001, early: 1'b1, dest: 8'd4, nb: 2'd2,
                    exp_dat: 64'h0000_0003_0002_0001, exp_keep: 8'h3F, exp_last: 2'b10};
        vecs[3] = '{nw: 3'd2, words: 64'h0000_0000_6666_5555, early: 1'b1, dest: 8'd4, nb: 2'd1,
                    exp_dat: 64'h0000_0000_6666_5555, exp_keep: 8'h0F, exp_last: 2'b01};
        vecs[4] = '{nw: 3'd4, words: 64'hCAFE_BEEF_C0DE_D00D, early: 1'b0, dest: 8'd9, nb: 2'd2,
                    exp_dat: 64'hCAFE_BEEF_C0DE_D00D, exp_keep: 8'hFF, exp_last: 2'b10};

        fork
            forever begin
                @(negedge clk);
                if (a_gp_tvalid === 1'b1 && a_gp_tready === 1'b1)
                    compare_beat("beat_a", '{dat: a_gp_tdata, keep: a_gp_tkeep, dest: a_gp_tdest,
                                 last: a_gp_tlast}, a_gp_tid, qa);
                if (b_gp_tvalid === 1'b1 && b_gp_tready === 1'b1)
                    compare_beat("beat_b", '{dat: {16'h0, b_gp_tdata}, keep: {2'b00, b_gp_tkeep},
                                 dest: b_gp_tdest, last: b_gp_tlast}, b_gp_tid, qb);
            end
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_axis_tready, a_gp_tvalid, a_gp_tdata, a_gp_tkeep, a_gp_tdest, a_gp_tlast} !== '0) begin
            failures++;
            $display("FAIL reset_a got tready=%b tvalid=%b dat=%h keep=%h dest=%h last=%b required all 0",
                     a_axis_tready, a_gp_tvalid, a_gp_tdata, a_gp_tkeep, a_gp_tdest, a_gp_tlast);
        end
        checks++;
        if ({b_axis_tready, b_gp_tvalid, b_gp_tdata, b_gp_tkeep, b_gp_tdest, b_gp_tlast} !== '0) begin
            failures++;
            $display("FAIL reset_b got tready=%b tvalid=%b dat=%h keep=%h dest=%h last=%b required all 0",
                     b_axis_tready, b_gp_tvalid, b_gp_tdata, b_gp_tkeep, b_gp_tdest, b_gp_tlast);
        end
        @(posedge clk);
        #1 aresetn = 1'b1;
        @(negedge clk);
        checks++;
        if (a_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL tready_after_reset got %b required 1", a_axis_tready);
        end
        @(posedge clk);
        #1;

        // Table of packets: full, early TLAST, restart, early TLAST on last slot, other dest.
        for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

        // Backpressure: beat held for 5 cycles while a further word is offered.
        push_a(32'h0B0B_0A0A, 4'hF, 8'd4, 1'b0);
        push_a(32'h0D0D_0C0C, 4'hF, 8'd4, 1'b1);
        a_dest = 8'd4;
        send_word(1'b0, 16'h0A0A, 1'b0);
        a_gp_tready = 1'b0;
        send_word(1'b0, 16'h0B0B, 1'b0);
        a_axis_tvalid = 1'b1; a_axis_tdata = 16'h0C0C; a_axis_tlast = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (!(a_gp_tvalid === 1'b1 && a_gp_tdata === 32'h0B0B_0A0A && a_gp_tkeep === 4'hF &&
                  a_gp_tdest === 8'd4 && a_gp_tlast === 1'b0 && a_axis_tready === 1'b0)) begin
                failures++;
                $display("FAIL stall_hold got tvalid=%b dat=%h keep=%h dest=%h last=%b tready=%b required 1 0b0b0a0a f 04 0 0",
                         a_gp_tvalid, a_gp_tdata, a_gp_tkeep, a_gp_tdest, a_gp_tlast, a_axis_tready);
            end
        end
        @(posedge clk);
        #1 a_gp_tready = 1'b1;
        send_word(1'b0, 16'h0C0C, 1'b0);
        send_word(1'b0, 16'h0D0D, 1'b0);

        // Destination change after the first word must not affect the current packet.
        push_a(32'h0304_0102, 4'hF, 8'd4, 1'b0);
        push_a(32'h0708_0506, 4'hF, 8'd4, 1'b1);
        a_dest = 8'd4;
        send_word(1'b0, 16'h0102, 1'b0);
        a_dest = 8'd7;
        send_word(1'b0, 16'h0304, 1'b0);
        send_word(1'b0, 16'h0506, 1'b0);
        send_word(1'b0, 16'h0708, 1'b0);
        tv = '{nw: 3'd4, words: 64'h0004_0003_0002_0001, early: 1'b0, dest: 8'd7, nb: 2'd2,
               exp_dat: 64'h0004_0003_0002_0001, exp_keep: 8'hFF, exp_last: 2'b10};
        apply_vec(tv);

        // Reset after one accepted word discards the partial packet.
        a_dest = 8'd4;
        send_word(1'b0, 16'h9999, 1'b0);
        aresetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_axis_tready, a_gp_tvalid, a_gp_tdata, a_gp_tkeep, a_gp_tdest, a_gp_tlast} !== '0) begin
            failures++;
            $display("FAIL reset_mid got tready=%b tvalid=%b dat=%h keep=%h dest=%h last=%b required all 0",
                     a_axis_tready, a_gp_tvalid, a_gp_tdata, a_gp_tkeep, a_gp_tdest, a_gp_tlast);
        end
        @(posedge clk);
        #1 aresetn = 1'b1;
        @(negedge clk);
        checks++;
        if (a_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL tready_after_reset_mid got %b required 1", a_axis_tready);
        end
        @(posedge clk);
        #1;
        apply_vec(vecs[0]);

        // W=1, N=3: one beat per word, TLAST on the third.
        eb = '{dat: 32'h0000_0011, keep: 4'h3, dest: 8'd5, last: 1'b0}; qb.push_back(eb);
        eb = '{dat: 32'h0000_0022, keep: 4'h3, dest: 8'd5, last: 1'b0}; qb.push_back(eb);
        eb = '{dat: 32'h0000_0033, keep: 4'h3, dest: 8'd5, last: 1'b1}; qb.push_back(eb);
        send_word(1'b1, 16'h0011, 1'b0);
        send_word(1'b1, 16'h0022, 1'b0);
        send_word(1'b1, 16'h0033, 1'b0);

        for (int c = 0; c < 50 && (qa.size() != 0 || qb.size() != 0); c++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (qa.size() != 0) begin
            failures++;
            $display("FAIL drain_a got %0d pending beats required 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            failures++;
            $display("FAIL drain_b got %0d pending beats required 0", qb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
